// File: rtl/jit_sequencer_if.sv
// Opcode, ROM, emitter and status signals of the JVM-to-ARM micro-sequencer.
// master = sequencer side, slave = surrounding environment (decoder, ROMs, emitter).
interface jit_sequencer_if;
    logic       op_valid;
    logic [7:0] op_code;
    logic       op_ready;
    logic [8:0] rom_adr;
    logic [6:0] rom_inst;
    logic [8:0] rom_next;
    logic       inst_valid;
    logic [6:0] inst_id;
    logic       inst_ready;
    logic       seq_done;
    logic [5:0] inst_cnt;
    logic       err;
    logic [1:0] err_code;
    logic       err_clr;

    modport master (
        input  op_valid, op_code, rom_inst, rom_next, inst_ready, err_clr,
        output op_ready, rom_adr, inst_valid, inst_id, seq_done, inst_cnt, err, err_code
    );

    modport slave (
        output op_valid, op_code, rom_inst, rom_next, inst_ready, err_clr,
        input  op_ready, rom_adr, inst_valid, inst_id, seq_done, inst_cnt, err, err_code
    );
endinterface

// File: rtl/jit_sequencer.sv
// Walks the instruction-id / next-address ROM chain for one JVM opcode and emits ARM ids.
// Define JIT_SEQ_LOOP_GUARD_EN to bound each chain to MAX_STEPS lookups (err_code 2).
module jit_sequencer #(
    parameter int unsigned MAX_STEPS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    jit_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_ERR} state_t;

    localparam logic [5:0] STEP_LIMIT = 6'(MAX_STEPS);
    localparam logic [6:0] INST_BAD   = 7'h7F;

    state_t     state_q;
    logic [8:0] adr_q;
    logic [6:0] inst_q;
    logic [8:0] next_q;
    logic [5:0] cnt_q;
    logic       first_q;
    logic       done_q;
    logic [1:0] err_code_q;
    logic       at_limit;

`ifdef JIT_SEQ_LOOP_GUARD_EN
    logic [5:0] step_q;
    assign at_limit = (step_q == STEP_LIMIT);
`else
    logic unused_step_limit;
    assign unused_step_limit = ^STEP_LIMIT;
    assign at_limit = 1'b0;
`endif

    assign bus.op_ready   = (state_q == S_IDLE);
    assign bus.inst_valid = (state_q == S_EMIT);
    assign bus.err        = (state_q == S_ERR);
    assign bus.rom_adr    = adr_q;
    assign bus.inst_id    = inst_q;
    assign bus.inst_cnt   = cnt_q;
    assign bus.seq_done   = done_q;
    assign bus.err_code   = err_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            inst_q     <= '0;
            next_q     <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
            err_code_q <= 2'd0;
`ifdef JIT_SEQ_LOOP_GUARD_EN
            step_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        adr_q   <= {1'b0, bus.op_code};
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        state_q <= S_LOOKUP;
`ifdef JIT_SEQ_LOOP_GUARD_EN
                        step_q  <= 6'd1;
`endif
                    end
                end
                S_LOOKUP: begin
                    first_q <= 1'b0;
                    if (bus.rom_inst == INST_BAD) begin
                        err_code_q <= 2'd1;
                        state_q    <= S_ERR;
                    end else if (bus.rom_inst == 7'd0) begin
                        // A zero/zero entry on the very first lookup means the opcode has no translation.
                        if (bus.rom_next == 9'd0) begin
                            if (first_q) begin
                                err_code_q <= 2'd3;
                                state_q    <= S_ERR;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else if (at_limit) begin
                            err_code_q <= 2'd2;
                            state_q    <= S_ERR;
                        end else begin
                            adr_q <= bus.rom_next;
`ifdef JIT_SEQ_LOOP_GUARD_EN
                            step_q <= step_q + 6'd1;
`endif
                        end
                    end else begin
                        inst_q  <= bus.rom_inst;
                        next_q  <= bus.rom_next;
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.inst_ready) begin
                        if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
                        if (next_q == 9'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (at_limit) begin
                            err_code_q <= 2'd2;
                            state_q    <= S_ERR;
                        end else begin
                            adr_q   <= next_q;
                            state_q <= S_LOOKUP;
`ifdef JIT_SEQ_LOOP_GUARD_EN
                            step_q  <= step_q + 6'd1;
`endif
                        end
                    end
                end
                S_ERR: begin
                    if (bus.err_clr) begin
                        err_code_q <= 2'd0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jit_sequencer.sv
// Directed bench for jit_sequencer: stub ROM tables, one task per scenario.
module tb_jit_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jit_sequencer_if bus();

    jit_sequencer #(.MAX_STEPS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] rom_inst_tbl [0:511];
    logic [8:0] rom_next_tbl [0:511];
    assign bus.rom_inst = rom_inst_tbl[bus.rom_adr];
    assign bus.rom_next = rom_next_tbl[bus.rom_adr];

    int ids[$];
    int valid_idx[$];
    int done_cnt;
    int err_idx;

    // Samples outputs at the current negedge, then advances one cycle, n times.
    task automatic collect(input int n);
        ids.delete(); valid_idx.delete(); done_cnt = 0; err_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (bus.inst_valid && bus.inst_ready) begin
                ids.push_back(int'(bus.inst_id));
                valid_idx.push_back(i);
            end
            if (bus.seq_done) done_cnt++;
            if (bus.err && err_idx < 0) err_idx = i;
            @(negedge clk);
        end
    endtask

    task automatic issue_op(input logic [7:0] code);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL rst_op_ready: got %0d expected 1", bus.op_ready); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %0d expected 0", bus.inst_valid); end
        checks++; if ({bus.err, bus.err_code, bus.seq_done} !== 4'd0) begin errors++; $display("FAIL rst_err: got %0h expected 0", {bus.err, bus.err_code, bus.seq_done}); end
        checks++; if (bus.rom_adr !== 9'd0 || bus.inst_cnt !== 6'd0 || bus.inst_id !== 7'd0) begin errors++; $display("FAIL rst_regs: adr %0h cnt %0d id %0d expected 0", bus.rom_adr, bus.inst_cnt, bus.inst_id); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released op_ready=%0d", bus.op_ready);
    endtask

    task automatic test_two_ids();
        bus.inst_ready = 1'b1;
        issue_op(8'h0B);
        checks++; if (bus.rom_adr !== 9'h00B) begin errors++; $display("FAIL 0b_rom_adr: got %0h expected 00b", bus.rom_adr); end
        checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL 0b_busy: op_ready got %0d expected 0", bus.op_ready); end
        collect(8);
        $display("opcode 0x0b ids=%0d done=%0d cnt=%0d", ids.size(), done_cnt, bus.inst_cnt);
        checks++; if (ids.size() != 2) begin errors++; $display("FAIL 0b_id_count: got %0d expected 2", ids.size()); end
        else begin
            checks++; if (ids[0] != 11 || ids[1] != 10) begin errors++; $display("FAIL 0b_ids: got %0d,%0d expected 11,10", ids[0], ids[1]); end
            checks++; if (valid_idx[0] != 1 || valid_idx[1] != 3) begin errors++; $display("FAIL 0b_latency: got %0d,%0d expected 1,3", valid_idx[0], valid_idx[1]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL 0b_seq_done: got %0d expected 1", done_cnt); end
        checks++; if (bus.inst_cnt !== 6'd2) begin errors++; $display("FAIL 0b_inst_cnt: got %0d expected 2", bus.inst_cnt); end
    endtask

    task automatic test_unsupported();
        issue_op(8'h01);
        collect(4);
        $display("opcode 0x01 err=%0d code=%0d", bus.err, bus.err_code);
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'd3) begin errors++; $display("FAIL unsup_err: got err %0d code %0d expected 1/3", bus.err, bus.err_code); end
        checks++; if (ids.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL unsup_quiet: ids %0d done %0d expected 0/0", ids.size(), done_cnt); end
        bus.op_valid = 1'b1;
        bus.op_code  = 8'h0B;
        @(negedge clk);
        bus.op_valid = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.op_ready !== 1'b0) begin errors++; $display("FAIL err_ignores_op: err %0d op_ready %0d expected 1/0", bus.err, bus.op_ready); end
        clear_err();
        checks++; if (bus.op_ready !== 1'b1 || bus.err !== 1'b0 || bus.err_code !== 2'd0) begin errors++; $display("FAIL err_clr: op_ready %0d err %0d code %0d expected 1/0/0", bus.op_ready, bus.err, bus.err_code); end
    endtask

    task automatic test_stall();
        int waited;
        int bad;
        bus.inst_ready = 1'b0;
        issue_op(8'h60);
        checks++; if (bus.inst_cnt !== 6'd0) begin errors++; $display("FAIL stall_cnt_restart: got %0d expected 0", bus.inst_cnt); end
        waited = 0;
        while (!bus.inst_valid && waited < 10) begin @(negedge clk); waited++; end
        checks++; if (waited != 2) begin errors++; $display("FAIL stall_wait: got %0d cycles expected 2", waited); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.inst_valid !== 1'b1 || bus.inst_id !== 7'd24) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles expected 0", bad); end
        bus.inst_ready = 1'b1;
        collect(4);
        $display("opcode 0x60 ids=%0d done=%0d cnt=%0d", ids.size(), done_cnt, bus.inst_cnt);
        checks++; if (ids.size() != 1 || (ids.size() == 1 && ids[0] != 24)) begin errors++; $display("FAIL 60_ids: got %0d ids expected one id 24", ids.size()); end
        checks++; if (done_cnt != 1 || bus.inst_cnt !== 6'd1) begin errors++; $display("FAIL 60_done: done %0d cnt %0d expected 1/1", done_cnt, bus.inst_cnt); end
    endtask

    task automatic test_loop_guard();
        issue_op(8'h40);
`ifdef JIT_SEQ_LOOP_GUARD_EN
        collect(40);
        $display("opcode 0x40 err_idx=%0d code=%0d", err_idx, bus.err_code);
        checks++; if (err_idx != 32) begin errors++; $display("FAIL loop_err_time: got %0d expected 32", err_idx); end
        checks++; if (bus.err_code !== 2'd2) begin errors++; $display("FAIL loop_err_code: got %0d expected 2", bus.err_code); end
        clear_err();
`else
        collect(100);
        $display("opcode 0x40 err_idx=%0d busy=%0d", err_idx, !bus.op_ready);
        checks++; if (err_idx != -1) begin errors++; $display("FAIL loop_no_err: got err at %0d expected none", err_idx); end
        checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL loop_busy: op_ready got %0d expected 0", bus.op_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL loop_recover: op_ready got %0d expected 1", bus.op_ready); end
    endtask

    task automatic test_reset_in_emit();
        int waited;
        bus.inst_ready = 1'b0;
        issue_op(8'h0B);
        waited = 0;
        while (!bus.inst_valid && waited < 10) begin @(negedge clk); waited++; end
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL emit_reach: inst_valid got %0d expected 1", bus.inst_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL async_rst: inst_valid %0d op_ready %0d expected 0/1", bus.inst_valid, bus.op_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        collect(6);
        $display("reset in emit ids=%0d done=%0d", ids.size(), done_cnt);
        checks++; if (ids.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL rst_abandon: ids %0d done %0d expected 0/0", ids.size(), done_cnt); end
    endtask

    task automatic test_invalid_adr();
        bus.inst_ready = 1'b1;
        issue_op(8'h22);
        collect(6);
        $display("opcode 0x22 err=%0d code=%0d ids=%0d", bus.err, bus.err_code, ids.size());
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'd1) begin errors++; $display("FAIL bad_adr_err: err %0d code %0d expected 1/1", bus.err, bus.err_code); end
        checks++; if (ids.size() != 0) begin errors++; $display("FAIL bad_adr_ids: got %0d expected 0", ids.size()); end
        clear_err();
    endtask

    task automatic test_back_to_back();
        bus.inst_ready = 1'b1;
        issue_op(8'h0B);
        collect(6);
        issue_op(8'h0B);
        collect(6);
        $display("back-to-back 0x0b ids=%0d done=%0d cnt=%0d", ids.size(), done_cnt, bus.inst_cnt);
        checks++; if (ids.size() != 2 || done_cnt != 1 || bus.inst_cnt !== 6'd2) begin errors++; $display("FAIL b2b: ids %0d done %0d cnt %0d expected 2/1/2", ids.size(), done_cnt, bus.inst_cnt); end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            rom_inst_tbl[a] = 7'h7F;
            rom_next_tbl[a] = 9'd0;
        end
        rom_inst_tbl[9'h00B] = 7'd11; rom_next_tbl[9'h00B] = 9'h10B;
        rom_inst_tbl[9'h10B] = 7'd10; rom_next_tbl[9'h10B] = 9'h000;
        rom_inst_tbl[9'h001] = 7'd0;  rom_next_tbl[9'h001] = 9'h000;
        rom_inst_tbl[9'h060] = 7'd0;  rom_next_tbl[9'h060] = 9'h120;
        rom_inst_tbl[9'h120] = 7'd24; rom_next_tbl[9'h120] = 9'h000;
        rom_inst_tbl[9'h040] = 7'd0;  rom_next_tbl[9'h040] = 9'h040;
        rom_inst_tbl[9'h022] = 7'd0;  rom_next_tbl[9'h022] = 9'h1FF;
        rom_inst_tbl[9'h1FF] = 7'h7F; rom_next_tbl[9'h1FF] = 9'h000;
        bus.op_valid   = 1'b0;
        bus.op_code    = 8'h00;
        bus.inst_ready = 1'b0;
        bus.err_clr    = 1'b0;

        test_reset();
        test_two_ids();
        test_unsupported();
        test_stall();
        test_loop_guard();
        test_reset_in_emit();
        test_invalid_adr();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
